alu_serial: RTL and testbench
=============================

Name: alu_serial

Overview:
- Parametrised successor to the core's single-cycle 8-bit ALU.
- Executes multi-byte arithmetic, logic and shift/rotate ops one byte per cycle through a single 8-bit lane, chaining carry between lanes.
- Serves 16-bit ops (ADD HL,rr; INC/DEC rr; SP adjust) and any wider ops the sequencer needs.
- Sits beside the register file and is driven by the decoder through a start/done handshake.

Parameters:
- NBYTES, 2: operand width in bytes (>=1); the datapath width is NBYTES*8.
- LANE_W, 8: lane width. Fixed at 8; any other value is a configuration error, checked at elaboration.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only in IDLE or in the DONE cycle.
- flush  in  1  synchronous abort; returns the block to IDLE without asserting done.
- op  in  alu_op_t  operation, sampled with start.
- acc_in  in  NBYTES*8  accumulator operand, sampled with start.
- arg_in  in  NBYTES*8  second operand, sampled with start.
- c_in  in  1  carry flag input, sampled with start.
- busy  out  1  high while lanes are being processed.
- done  out  1  one-cycle pulse; result and flags are valid.
- res  out  NBYTES*8  result; held until the next accepted start.
- f_out  out  flags_t  {z,n,h,c}; held with res.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, busy=0, done=0, res=0, f_out=0, lane index=0.
- States are IDLE, BUSY and DONE. DONE lasts exactly one cycle.
- Acceptance: when start is high at edge E0 in IDLE or DONE, the block latches op, operands and c_in, sets lane idx to 0 and enters BUSY.
- Lane processing: one lane per edge, E1..E_NBYTES.
  - busy is high from after E0 through E_NBYTES.
  - After E_NBYTES: state DONE, done=1, busy=0, res and f_out registered.
  - Latency from start to done is NBYTES cycles. NBYTES=1 gives done one cycle after start.
- Back-to-back: start in the DONE cycle is accepted, so throughput is one op per NBYTES cycles.
- start while in BUSY is ignored.
- flush: takes priority over start and lane progress. It forces IDLE, busy=0, done=0 and leaves res/f_out at their last completed values.
- Lane order:
  - LSB-first (lane 0 first) for ADD, ADC, SUB, SBC, CP, AND, OR, XOR, RL and SLA.
  - MSB-first for RR and SRL, so carry flows downward.
- Carry chain:
  - Carry into the first lane: c_in for ADC/SBC/RL/RR, 0 for the others.
  - Lane carry-out feeds the next lane's carry-in.
  - SUB, SBC and CP compute acc - arg - borrow. h and c report borrow out of bit 3 and bit 7 of each lane.
- Shifts, one bit across the full width:
  - RL: LSB gets carry-in; c gets the old MSB.
  - RR: MSB gets carry-in; c gets the old LSB.
  - SLA: LSB gets 0; c gets the old MSB.
  - SRL: MSB gets 0; c gets the old LSB.
- Flags:
  - z=1 iff the whole NBYTES*8 result is 0, accumulated across lanes as an OR-reduction.
  - n=1 for SUB/SBC/CP, else 0.
  - h comes from the final arithmetic lane, i.e. bit 11 carry/borrow when NBYTES=2.
  - c comes from the final lane's carry/borrow.
  - Logic ops: n=h=c=0, consistent with the existing core.
  - Shifts: n=h=0.
- CP: flags as for SUB; res = latched acc_in (unchanged).
- Undefined op values behave as ADD.

Decomposition:
- Shared package (with the existing defs):
  - alu_op_t, extended with ALU_RL, ALU_RR, ALU_SLA, ALU_SRL.
  - flags_t.
  - Enum for the state type: ALUS_IDLE, ALUS_BUSY, ALUS_DONE.
- One combinational sub-module, alu_lane, instantiated once.
  - Inputs: op, acc byte, arg byte, cin, shift-in bit, lane position.
  - Outputs: byte, cout, hout.
- The top level holds operand shift registers, the lane counter, the z accumulator and the FSM.

Test Plan:
1. NBYTES=2, ADD, acc=0x0FFF, arg=0x0001, c_in=0 -> done exactly 2 cycles after start; res=0x1000, f={z0,n0,h1,c0}.
2. SUB, 0x1000-0x0001 -> res=0x0FFF, f={0,1,1,0}. Then CP 0x1234 vs 0x1234 -> res=0x1234, f={1,1,0,0}.
3. RR, acc=0x0001, c_in=1 -> res=0x8000, f={0,0,0,1}. Then RL, acc=0x8000, c_in=0 -> res=0x0000, f={1,0,0,1}.
4. Back-to-back: XOR 0xFFFF^0xFFFF with start re-asserted in its done cycle for ADC 0xFFFF+0x0000, c_in=1.
   - First op: res=0x0000, f={1,0,0,0}.
   - Second op: res=0x0000, f={1,0,1,1}; its done follows 2 cycles later.
   - start pulses during BUSY are ignored.
5. Abort: ADD accepted, then flush one cycle later -> busy=0 next cycle, no done, res/f_out keep the prior values. rst pulsed low mid-op -> all outputs 0 immediately, without waiting for a clk edge.
6. NBYTES=1 and NBYTES=4 builds: ADD 0xFF+0x01 -> 0x00, f={1,0,1,1}, latency 1. ADD 0x0000FFFF+0x00000001 -> 0x00010000, f={0,0,0,0}, latency 4.

Source files
------------

// File: rtl/alu_serial_pkg.sv
// Shared types for the serial multi-byte ALU: op codes, flag bundle, sequencer states
// and small op-classification helpers.
package alu_serial_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_ADC = 4'd1,
    ALU_SUB = 4'd2,
    ALU_SBC = 4'd3,
    ALU_AND = 4'd4,
    ALU_XOR = 4'd5,
    ALU_OR  = 4'd6,
    ALU_CP  = 4'd7,
    ALU_RL  = 4'd8,
    ALU_RR  = 4'd9,
    ALU_SLA = 4'd10,
    ALU_SRL = 4'd11
  } alu_op_t;

  typedef struct packed {
    logic z;
    logic n;
    logic h;
    logic c;
  } flags_t;

  typedef enum logic [1:0] {
    ALUS_IDLE = 2'd0,
    ALUS_BUSY = 2'd1,
    ALUS_DONE = 2'd2
  } alus_state_t;

  // Unassigned encodings collapse to ADD so the lane never sees them.
  function automatic alu_op_t norm_op(input alu_op_t op);
    case (op)
      ALU_ADD, ALU_ADC, ALU_SUB, ALU_SBC, ALU_AND, ALU_XOR,
      ALU_OR, ALU_CP, ALU_RL, ALU_RR, ALU_SLA, ALU_SRL: norm_op = op;
      default: norm_op = ALU_ADD;
    endcase
  endfunction

  function automatic logic is_sub_op(input alu_op_t op);
    is_sub_op = (op == ALU_SUB) || (op == ALU_SBC) || (op == ALU_CP);
  endfunction

  function automatic logic uses_cin(input alu_op_t op);
    uses_cin = (op == ALU_ADC) || (op == ALU_SBC) || (op == ALU_RL) || (op == ALU_RR);
  endfunction

  function automatic logic msb_first(input alu_op_t op);
    msb_first = (op == ALU_RR) || (op == ALU_SRL);
  endfunction

endpackage

// File: rtl/alu_lane.sv
// One 8-bit ALU lane: arithmetic, logic or one-bit shift of a single byte,
// with carry/borrow and half-carry outputs for chaining to the next lane.
module alu_lane
  import alu_serial_pkg::*;
(
  input  alu_op_t    op,
  input  logic [7:0] acc,
  input  logic [7:0] arg,
  input  logic       cin,
  input  logic       shin,
  input  logic       first_lane,
  output logic [7:0] res,
  output logic       cout,
  output logic       hout
);

  logic       c_eff_s;
  logic       s_eff_s;
  logic [8:0] sum9_s;
  logic [4:0] lo5_s;

  // Byte result and carries; the first lane only sees the flag carry for ops that consume it.
  always_comb begin
    c_eff_s = first_lane ? (uses_cin(op) & cin) : cin;
    s_eff_s = first_lane ? (uses_cin(op) & shin) : shin;
    sum9_s  = 9'd0;
    lo5_s   = 5'd0;
    res     = 8'd0;
    cout    = 1'b0;
    hout    = 1'b0;
    case (op)
      ALU_SUB, ALU_SBC, ALU_CP: begin
        sum9_s = {1'b0, acc} - {1'b0, arg} - {8'd0, c_eff_s};
        lo5_s  = {1'b0, acc[3:0]} - {1'b0, arg[3:0]} - {4'd0, c_eff_s};
        res    = sum9_s[7:0];
        cout   = sum9_s[8];
        hout   = lo5_s[4];
      end
      ALU_AND: res = acc & arg;
      ALU_OR:  res = acc | arg;
      ALU_XOR: res = acc ^ arg;
      ALU_RL, ALU_SLA: begin
        res  = {acc[6:0], s_eff_s};
        cout = acc[7];
      end
      ALU_RR, ALU_SRL: begin
        res  = {s_eff_s, acc[7:1]};
        cout = acc[0];
      end
      default: begin
        sum9_s = {1'b0, acc} + {1'b0, arg} + {8'd0, c_eff_s};
        lo5_s  = {1'b0, acc[3:0]} + {1'b0, arg[3:0]} + {4'd0, c_eff_s};
        res    = sum9_s[7:0];
        cout   = sum9_s[8];
        hout   = lo5_s[4];
      end
    endcase
  end

endmodule

// File: rtl/alu_serial.sv
// Serial multi-byte ALU: pushes NBYTES operand bytes through one 8-bit lane,
// chaining carry between lanes, under a start/done handshake with synchronous flush.
module alu_serial
  import alu_serial_pkg::*;
#(
  parameter int NBYTES = 2,
  parameter int LANE_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       flush,
  input  alu_op_t                    op,
  input  logic [NBYTES*LANE_W-1:0]   acc_in,
  input  logic [NBYTES*LANE_W-1:0]   arg_in,
  input  logic                       c_in,
  output logic                       busy,
  output logic                       done,
  output logic [NBYTES*LANE_W-1:0]   res,
  output flags_t                     f_out
);

  localparam int W  = NBYTES * LANE_W;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  if (LANE_W != 8 || NBYTES < 1) begin : g_cfg_check
    $error("alu_serial: LANE_W must be 8 and NBYTES >= 1");
  end

  alus_state_t   state_r, state_nx;
  logic          busy_r, done_r;
  alu_op_t       op_r;
  logic [W-1:0]  acc_sr, arg_sr, res_sr;
  logic [W-1:0]  acc_nx_s, arg_nx_s, res_nx_s;
  logic          carry_r, nz_r;
  logic [IW-1:0] idx_r;
  logic          msb_s, first_s, last_s, accept_s;
  logic [7:0]    acc_b_s, arg_b_s, lane_res_s;
  logic          lane_c_s, lane_h_s;
  flags_t        flags_nx_s;

  assign msb_s    = msb_first(op_r);
  assign first_s  = (idx_r == IW'(0));
  assign last_s   = (idx_r == IW'(NBYTES - 1));
  assign accept_s = start && (state_r != ALUS_BUSY);
  assign acc_b_s  = msb_s ? acc_sr[W-1 -: LANE_W] : acc_sr[LANE_W-1:0];
  assign arg_b_s  = msb_s ? arg_sr[W-1 -: LANE_W] : arg_sr[LANE_W-1:0];

  alu_lane u_lane (
    .op         (op_r),
    .acc        (acc_b_s),
    .arg        (arg_b_s),
    .cin        (carry_r),
    .shin       (carry_r),
    .first_lane (first_s),
    .res        (lane_res_s),
    .cout       (lane_c_s),
    .hout       (lane_h_s)
  );

  // Operands rotate rather than shift so the original acc is back in place for CP.
  always_comb begin
    acc_nx_s = acc_sr;
    arg_nx_s = arg_sr;
    res_nx_s = res_sr;
    if (msb_s) begin
      acc_nx_s = (acc_sr << LANE_W) | (acc_sr >> (W - LANE_W));
      arg_nx_s = (arg_sr << LANE_W) | (arg_sr >> (W - LANE_W));
      res_nx_s = (res_sr << LANE_W) | W'(lane_res_s);
    end else begin
      acc_nx_s = (acc_sr >> LANE_W) | (acc_sr << (W - LANE_W));
      arg_nx_s = (arg_sr >> LANE_W) | (arg_sr << (W - LANE_W));
      res_nx_s = (res_sr >> LANE_W) | (W'(lane_res_s) << (W - LANE_W));
    end
    flags_nx_s.z = ~(nz_r | (|lane_res_s));
    flags_nx_s.n = is_sub_op(op_r);
    flags_nx_s.h = lane_h_s;
    flags_nx_s.c = lane_c_s;
  end

  // Sequencer next state; flush overrides both acceptance and lane progress.
  always_comb begin
    state_nx = state_r;
    if (flush) begin
      state_nx = ALUS_IDLE;
    end else begin
      case (state_r)
        ALUS_IDLE: state_nx = start ? ALUS_BUSY : ALUS_IDLE;
        ALUS_BUSY: state_nx = last_s ? ALUS_DONE : ALUS_BUSY;
        ALUS_DONE: state_nx = start ? ALUS_BUSY : ALUS_IDLE;
        default:   state_nx = ALUS_IDLE;
      endcase
    end
  end

  // State register with registered busy/done decodes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ALUS_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      busy_r  <= (state_nx == ALUS_BUSY);
      done_r  <= (state_nx == ALUS_DONE);
    end
  end

  // Operand capture, lane stepping and result/flag commit on the last lane.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r    <= ALU_ADD;
      acc_sr  <= '0;
      arg_sr  <= '0;
      res_sr  <= '0;
      carry_r <= 1'b0;
      nz_r    <= 1'b0;
      idx_r   <= '0;
      res     <= '0;
      f_out   <= '0;
    end else if (flush) begin
      idx_r <= '0;
    end else if (accept_s) begin
      op_r    <= norm_op(op);
      acc_sr  <= acc_in;
      arg_sr  <= arg_in;
      res_sr  <= '0;
      carry_r <= c_in;
      nz_r    <= 1'b0;
      idx_r   <= '0;
    end else if (state_r == ALUS_BUSY) begin
      acc_sr  <= acc_nx_s;
      arg_sr  <= arg_nx_s;
      res_sr  <= res_nx_s;
      carry_r <= lane_c_s;
      nz_r    <= nz_r | (|lane_res_s);
      idx_r   <= idx_r + IW'(1);
      if (last_s) begin
        res   <= (op_r == ALU_CP) ? acc_nx_s : res_nx_s;
        f_out <= flags_nx_s;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: three builds (1, 2, 4 bytes) share stimulus and are checked
// against a whole-width arithmetic reference model.
module tb_alu_serial;
  import alu_serial_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush, c_in;
  alu_op_t     op;
  logic [31:0] acc, arg;
  logic        busy1, done1, busy2, done2, busy4, done4;
  logic [7:0]  res1;
  logic [15:0] res2;
  logic [31:0] res4;
  logic [3:0]  f1, f2, f4;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  alu_serial #(.NBYTES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .acc_in(acc[7:0]), .arg_in(arg[7:0]), .c_in(c_in),
    .busy(busy1), .done(done1), .res(res1), .f_out(f1));

  alu_serial #(.NBYTES(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .acc_in(acc[15:0]), .arg_in(arg[15:0]), .c_in(c_in),
    .busy(busy2), .done(done2), .res(res2), .f_out(f2));

  alu_serial #(.NBYTES(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .op(op),
    .acc_in(acc), .arg_in(arg), .c_in(c_in),
    .busy(busy4), .done(done4), .res(res4), .f_out(f4));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {z,n,h,c, result[31:0]} for an nb-byte operation on whole-width integers.
  function automatic logic [35:0] model(input logic [3:0] opc, input logic [31:0] a_in,
                                        input logic [31:0] b_in, input logic ci, input int nb);
    longint unsigned mask, hm, a, b, cc, r, full;
    int   w;
    logic z, n, h, c;
    w    = nb * 8;
    mask = (64'd1 << w) - 64'd1;
    hm   = mask >> 4;
    a    = 64'(a_in) & mask;
    b    = 64'(b_in) & mask;
    n = 1'b0; h = 1'b0; c = 1'b0;
    case (opc)
      ALU_SUB, ALU_SBC, ALU_CP: begin
        cc   = (opc == ALU_SBC) ? 64'(ci) : 64'd0;
        full = (a - b - cc) & mask;
        c    = (a < b + cc);
        h    = ((a & hm) < (b & hm) + cc);
        n    = 1'b1;
        r    = (opc == ALU_CP) ? a : full;
        z    = (full == 64'd0);
      end
      ALU_AND: begin r = a & b; z = (r == 64'd0); end
      ALU_OR:  begin r = a | b; z = (r == 64'd0); end
      ALU_XOR: begin r = a ^ b; z = (r == 64'd0); end
      ALU_RL, ALU_SLA: begin
        cc = (opc == ALU_RL) ? 64'(ci) : 64'd0;
        r  = ((a << 1) | cc) & mask;
        c  = ((a >> (w - 1)) & 64'd1) != 64'd0;
        z  = (r == 64'd0);
      end
      ALU_RR, ALU_SRL: begin
        cc = (opc == ALU_RR) ? 64'(ci) : 64'd0;
        r  = (a >> 1) | (cc << (w - 1));
        c  = (a & 64'd1) != 64'd0;
        z  = (r == 64'd0);
      end
      default: begin
        cc   = (opc == ALU_ADC) ? 64'(ci) : 64'd0;
        full = a + b + cc;
        r    = full & mask;
        c    = ((full >> w) & 64'd1) != 64'd0;
        h    = ((((a & hm) + (b & hm) + cc) >> (w - 4)) & 64'd1) != 64'd0;
        z    = (r == 64'd0);
      end
    endcase
    model = {z, n, h, c, r[31:0]};
  endfunction

  // Issue one op to all three builds and check latency, done pulse width and results.
  task automatic run_op(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                        input logic ci);
    int lat1, lat2, lat4, npulse;
    logic [35:0] m;
    lat1 = 0; lat2 = 0; lat4 = 0; npulse = 0;
    @(negedge clk);
    op = alu_op_t'(opc); acc = a; arg = b; c_in = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (done1 && lat1 == 0) lat1 = k;
      if (done2 && lat2 == 0) lat2 = k;
      if (done4 && lat4 == 0) lat4 = k;
      if (done2) npulse++;
    end
    check_eq("lat_nb1", 32'(lat1), 32'd1);
    check_eq("lat_nb2", 32'(lat2), 32'd2);
    check_eq("lat_nb4", 32'(lat4), 32'd4);
    check_eq("done_pulse_nb2", 32'(npulse), 32'd1);
    m = model(opc, a, b, ci, 1);
    check_eq("res_nb1", 32'(res1), {24'd0, m[7:0]});
    check_eq("flags_nb1", 32'(f1), {28'd0, m[35:32]});
    m = model(opc, a, b, ci, 2);
    check_eq("res_nb2", 32'(res2), {16'd0, m[15:0]});
    check_eq("flags_nb2", 32'(f2), {28'd0, m[35:32]});
    m = model(opc, a, b, ci, 4);
    check_eq("res_nb4", res4, m[31:0]);
    check_eq("flags_nb4", 32'(f4), {28'd0, m[35:32]});
  endtask

  initial begin
    logic saw_done;
    rst = 1'b0; start = 1'b0; flush = 1'b0; c_in = 1'b0;
    op = ALU_ADD; acc = 32'd0; arg = 32'd0;
    #3;
    check_eq("rst_busy", {30'd0, busy2, busy4}, 32'd0);
    check_eq("rst_done", {29'd0, done1, done2, done4}, 32'd0);
    check_eq("rst_res", 32'(res2) | res4, 32'd0);
    check_eq("rst_flags", {20'd0, f1, f2, f4}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed cases with hand-derived 16-bit expectations
    run_op(ALU_ADD, 32'h0000_0FFF, 32'h0000_0001, 1'b0);
    check_eq("t1_res", 32'(res2), 32'h1000);
    check_eq("t1_flags", 32'(f2), 32'b0010);
    run_op(ALU_SUB, 32'h0000_1000, 32'h0000_0001, 1'b0);
    check_eq("t2_sub_res", 32'(res2), 32'h0FFF);
    check_eq("t2_sub_flags", 32'(f2), 32'b0110);
    run_op(ALU_CP, 32'h0000_1234, 32'h0000_1234, 1'b0);
    check_eq("t2_cp_res", 32'(res2), 32'h1234);
    check_eq("t2_cp_flags", 32'(f2), 32'b1100);
    run_op(ALU_RR, 32'h0000_0001, 32'h0, 1'b1);
    check_eq("t3_rr_res", 32'(res2), 32'h8000);
    check_eq("t3_rr_flags", 32'(f2), 32'b0001);
    run_op(ALU_RL, 32'h0000_8000, 32'h0, 1'b0);
    check_eq("t3_rl_res", 32'(res2), 32'h0000);
    check_eq("t3_rl_flags", 32'(f2), 32'b1001);
    run_op(ALU_ADD, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    check_eq("t6_nb1_res", 32'(res1), 32'h00);
    check_eq("t6_nb1_flags", 32'(f1), 32'b1011);
    check_eq("t6_nb4_res", res4, 32'h0001_0000);
    check_eq("t6_nb4_flags", 32'(f4), 32'b0000);
    run_op(4'd14, 32'h0000_00F8, 32'h0000_0009, 1'b1);
    run_op(ALU_SRL, 32'h8001_0003, 32'h0, 1'b1);
    run_op(ALU_SBC, 32'h0000_0000, 32'h0000_0000, 1'b1);

    // Back-to-back on the 2-byte build with start pulses during BUSY
    @(negedge clk);
    op = ALU_XOR; acc = 32'hFFFF; arg = 32'hFFFF; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    op = ALU_SUB; acc = 32'h0001; arg = 32'h0002;
    @(negedge clk);
    check_eq("b2b_busy_a", {30'd0, busy2, done2}, 32'b10);
    start = 1'b0;
    @(negedge clk);
    check_eq("b2b_done_a", 32'(done2), 32'd1);
    check_eq("b2b_res_a", 32'(res2), 32'h0000);
    check_eq("b2b_flags_a", 32'(f2), 32'b1000);
    op = ALU_ADC; acc = 32'hFFFF; arg = 32'h0000; c_in = 1'b1; start = 1'b1;
    @(negedge clk);
    check_eq("b2b_busy_b0", {30'd0, busy2, done2}, 32'b10);
    op = ALU_SUB; acc = 32'h0005; arg = 32'h0003; c_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    check_eq("b2b_busy_b1", {30'd0, busy2, done2}, 32'b10);
    @(negedge clk);
    check_eq("b2b_done_b", 32'(done2), 32'd1);
    check_eq("b2b_res_b", 32'(res2), 32'h0000);
    check_eq("b2b_flags_b", 32'(f2), 32'b1011);
    repeat (6) @(negedge clk);

    // Flush one cycle after acceptance: no done, prior result kept
    op = ALU_ADD; acc = 32'h1234; arg = 32'h0001; c_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b1;
    check_eq("flush_accepted", 32'(busy2), 32'd1);
    @(negedge clk);
    flush = 1'b0;
    check_eq("flush_idle", {30'd0, busy2, done2}, 32'd0);
    check_eq("flush_res_kept", 32'(res2), 32'h0000);
    check_eq("flush_flags_kept", 32'(f2), 32'b1011);
    saw_done = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done2) saw_done = 1'b1;
    end
    check_eq("flush_no_done", 32'(saw_done), 32'd0);

    // Asynchronous reset mid-operation
    run_op(ALU_ADD, 32'h0000_1234, 32'h0000_1111, 1'b0);
    @(negedge clk);
    op = ALU_OR; acc = 32'h00F0; arg = 32'h000F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_eq("arst_res", 32'(res2), 32'd0);
    check_eq("arst_flags", 32'(f2), 32'd0);
    check_eq("arst_ctl", {30'd0, busy2, done2}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Randomised ops, including unassigned encodings
    for (int i = 0; i < 40; i++) begin
      run_op(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
